hazard_ctrl: RTL and testbench

- Pipeline hazard/stall sequencer for the 5-stage RISC-V core.
- Detects load-use hazards and drives the bubble-select into the control-zeroing mux feeding ID/EX.
- Sequences branch-taken flushes, possibly over multiple cycles.
- Freezes the whole pipeline while a multi-cycle data-memory access waits for acknowledge, with a timeout/error path and a saturating stall-cycle counter.

---
 rtl/hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Load-use bubble, branch flush sequencing and memory-wait freeze for the 5-stage core.
// Outputs are combinational from state and inputs; stalls come from a pending data-memory ack.
module hazard_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int MEM_TIMEOUT  = 15,
   parameter int CNT_W        = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             id_rs1_used_i,
   input  logic             id_rs2_used_i,
   input  logic [4:0]       ex_rd_i,
   input  logic             ex_mem_read_i,
   input  logic             branch_taken_i,
   input  logic             mem_req_i,
   input  logic             mem_ack_i,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             idex_write_o,
   output logic             exmem_hold_o,
   output logic             hazard_o,
   output logic             ifid_flush_o,
   output logic             idex_flush_o,
   output logic             mem_err_o,
   output logic [CNT_W-1:0] stall_cycles_o
);

   typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

   localparam logic [7:0] TO_LIM    = 8'(MEM_TIMEOUT);
   localparam logic [3:0] FL_RELOAD = 4'(FLUSH_CYCLES - 1);

   state_t           state_q, state_d;
   logic [7:0]       wait_q, wait_d;
   logic [3:0]       flush_q, flush_d;
   logic [CNT_W-1:0] stall_q;
   logic             lu, mem_stall;

   assign lu = ex_mem_read_i && (ex_rd_i != 5'd0) &&
               ((id_rs1_used_i && (id_rs1_i == ex_rd_i)) ||
                (id_rs2_used_i && (id_rs2_i == ex_rd_i)));
   assign mem_stall = mem_req_i && !mem_ack_i;

   always_comb begin
      state_d      = state_q;
      wait_d       = wait_q;
      flush_d      = flush_q;
      pc_write_o   = 1'b1;
      ifid_write_o = 1'b1;
      idex_write_o = 1'b1;
      exmem_hold_o = 1'b0;
      hazard_o     = 1'b0;
      ifid_flush_o = 1'b0;
      idex_flush_o = 1'b0;
      mem_err_o    = 1'b0;
      if (rst_n_i) begin
         case (state_q)
            RUN: begin
               // A pending memory access freezes EX/ID, so branch and load-use re-present later.
               if (mem_stall) begin
                  pc_write_o   = 1'b0;
                  ifid_write_o = 1'b0;
                  idex_write_o = 1'b0;
                  exmem_hold_o = 1'b1;
                  state_d      = MEM_WAIT;
                  wait_d       = 8'd1;
               end else if (branch_taken_i) begin
                  ifid_flush_o = 1'b1;
                  idex_flush_o = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     state_d = FLUSH;
                     flush_d = FL_RELOAD;
                  end
               end else if (lu) begin
                  pc_write_o   = 1'b0;
                  ifid_write_o = 1'b0;
                  hazard_o     = 1'b1;
               end
            end
            MEM_WAIT: begin
               if (mem_ack_i) begin
                  state_d = RUN;
               end else if (wait_q == TO_LIM) begin
                  mem_err_o = 1'b1;
                  state_d   = RUN;
               end else begin
                  pc_write_o   = 1'b0;
                  ifid_write_o = 1'b0;
                  idex_write_o = 1'b0;
                  exmem_hold_o = 1'b1;
                  wait_d       = wait_q + 8'd1;
               end
            end
            FLUSH: begin
               if (mem_stall) begin
                  pc_write_o   = 1'b0;
                  ifid_write_o = 1'b0;
                  idex_write_o = 1'b0;
                  exmem_hold_o = 1'b1;
                  state_d      = MEM_WAIT;
                  wait_d       = 8'd1;
               end else begin
                  ifid_flush_o = 1'b1;
                  if (branch_taken_i) begin
                     idex_flush_o = 1'b1;
                     flush_d      = FL_RELOAD;
                     if (FL_RELOAD == 4'd0) state_d = RUN;
                  end else if (flush_q <= 4'd1) begin
                     flush_d = 4'd0;
                     state_d = RUN;
                  end else begin
                     flush_d = flush_q - 4'd1;
                  end
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= RUN;
         wait_q  <= 8'd0;
         flush_q <= 4'd0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         flush_q <= flush_d;
         if (!pc_write_o && (stall_q != {CNT_W{1'b1}}))
            stall_q <= stall_q + CNT_W'(1);
      end
   end

   assign stall_cycles_o = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: single-cycle vector table plus multi-cycle sequences.
module tb_hazard_ctrl;

   localparam logic [7:0] IDLE = 8'b1110_0000;
   localparam logic [7:0] FRZ  = 8'b0001_0000;
   localparam logic [7:0] HAZ  = 8'b0010_1000;
   localparam logic [7:0] BR   = 8'b1110_0110;
   localparam logic [7:0] FL   = 8'b1110_0100;
   localparam logic [7:0] ERR  = 8'b1110_0001;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] rs1, rs2, rd;
   logic       u1, u2, mr, br, req, ack;
   logic       pc_w, ifid_w, idex_w, hold, haz, ifid_fl, idex_fl, err;
   logic [3:0] stall;
   logic [7:0] outs;

   int n_cmp = 0;
   int n_bad = 0;

   hazard_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(15), .CNT_W(4)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs1_used_i(u1), .id_rs2_used_i(u2),
      .ex_rd_i(rd), .ex_mem_read_i(mr), .branch_taken_i(br),
      .mem_req_i(req), .mem_ack_i(ack),
      .pc_write_o(pc_w), .ifid_write_o(ifid_w), .idex_write_o(idex_w),
      .exmem_hold_o(hold), .hazard_o(haz), .ifid_flush_o(ifid_fl),
      .idex_flush_o(idex_fl), .mem_err_o(err), .stall_cycles_o(stall)
   );

   assign outs = {pc_w, ifid_w, idex_w, hold, haz, ifid_fl, idex_fl, err};

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before 200000");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string      name;
      logic [4:0] rs1, rs2, rd;
      logic       u1, u2, mr, br, req, ack;
      logic [7:0] exp;
      logic [3:0] exp_stall;
   } vec_t;

   function automatic vec_t mk(string n, logic [4:0] a, logic [4:0] b, logic ua, logic ub,
                               logic [4:0] d, logic m, logic bt, logic rq, logic ak,
                               logic [7:0] e, logic [3:0] s);
      vec_t v;
      v.name = n; v.rs1 = a; v.rs2 = b; v.u1 = ua; v.u2 = ub; v.rd = d; v.mr = m;
      v.br = bt; v.req = rq; v.ack = ak; v.exp = e; v.exp_stall = s;
      return v;
   endfunction

   task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, required %b", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0; mr = 0; br = 0; req = 0; ack = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clr_in();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   vec_t vt[$];

   initial begin
      rst_n = 1'b0;
      clr_in();

      vt.push_back(mk("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, 0));
      vt.push_back(mk("lu_rs2",      0, 5, 0, 1, 5, 1, 0, 0, 0, HAZ,  1));
      vt.push_back(mk("lu_rd0",      0, 0, 0, 1, 0, 1, 0, 0, 0, IDLE, 0));
      vt.push_back(mk("lu_rs1_unused",7,0, 0, 0, 7, 1, 0, 0, 0, IDLE, 0));
      vt.push_back(mk("lu_rs1",      7, 0, 1, 0, 7, 1, 0, 0, 0, HAZ,  1));
      vt.push_back(mk("no_load",     7, 7, 1, 1, 7, 0, 0, 0, 0, IDLE, 0));
      vt.push_back(mk("rs_mismatch", 3, 9, 1, 0, 9, 1, 0, 0, 0, IDLE, 0));
      vt.push_back(mk("branch",      0, 0, 0, 0, 0, 0, 1, 0, 0, BR,   0));
      vt.push_back(mk("branch_lu",   0, 5, 0, 1, 5, 1, 1, 0, 0, BR,   0));
      vt.push_back(mk("mem_stall",   0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  1));
      vt.push_back(mk("mem_zero_lat",0, 0, 0, 0, 0, 0, 0, 1, 1, IDLE, 0));
      vt.push_back(mk("mem_over_br", 0, 5, 0, 1, 5, 1, 1, 1, 0, FRZ,  1));

      // Each vector starts from a fresh reset so its single-cycle response is isolated.
      foreach (vt[i]) begin
         do_reset();
         rs1 = vt[i].rs1; rs2 = vt[i].rs2; u1 = vt[i].u1; u2 = vt[i].u2;
         rd = vt[i].rd; mr = vt[i].mr; br = vt[i].br; req = vt[i].req; ack = vt[i].ack;
         @(negedge clk);
         chk({vt[i].name, "_outs"}, outs, vt[i].exp);
         tick();
         clr_in();
         chk({vt[i].name, "_stall"}, {4'd0, stall}, {4'd0, vt[i].exp_stall});
      end

      // Reset held with a pending request: idle outputs, then RUN after release.
      rst_n = 1'b0;
      clr_in();
      req = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst_outs", outs, IDLE);
         tick();
      end
      chk("rst_stall", {4'd0, stall}, 8'd0);
      rst_n = 1'b1;
      req = 1'b0;
      @(negedge clk);
      chk("rst_release_run", outs, IDLE);

      // Reset during MEM_WAIT aborts without an error pulse.
      do_reset();
      req = 1'b1;
      tick();
      tick();
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_wait", outs, IDLE);
      tick();
      rst_n = 1'b1;
      req = 1'b0;
      @(negedge clk);
      chk("rst_mid_wait_after", outs, IDLE);

      // Taken branch with FLUSH_CYCLES=3.
      do_reset();
      br = 1'b1;
      @(negedge clk); chk("br_c1", outs, BR);
      tick(); br = 1'b0;
      @(negedge clk); chk("br_c2", outs, FL);
      tick();
      @(negedge clk); chk("br_c3", outs, FL);
      tick();
      @(negedge clk); chk("br_c4", outs, IDLE);

      // Second branch during FLUSH reloads the flush counter.
      do_reset();
      br = 1'b1;
      tick();
      @(negedge clk); chk("rebr_c2", outs, BR);
      tick(); br = 1'b0;
      @(negedge clk); chk("rebr_c3", outs, FL);
      tick();
      @(negedge clk); chk("rebr_c4", outs, FL);
      tick();
      @(negedge clk); chk("rebr_c5", outs, IDLE);

      // Memory stall arriving during FLUSH takes priority.
      do_reset();
      br = 1'b1;
      tick(); br = 1'b0; req = 1'b1;
      @(negedge clk); chk("fl_mem_frz", outs, FRZ);
      tick(); ack = 1'b1;
      @(negedge clk); chk("fl_mem_ack", outs, IDLE);
      tick(); clr_in();
      @(negedge clk); chk("fl_mem_after", outs, IDLE);

      // Memory ack after four freeze cycles.
      do_reset();
      req = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         chk($sformatf("memw_frz%0d", i), outs, FRZ);
         tick();
      end
      ack = 1'b1;
      @(negedge clk); chk("memw_ack", outs, IDLE);
      tick(); clr_in();
      @(negedge clk); chk("memw_after", outs, IDLE);
      chk("memw_stall", {4'd0, stall}, 8'd4);

      // Timeout: fifteen freeze cycles, then one error pulse with the freeze released.
      do_reset();
      req = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         chk($sformatf("to_frz%0d", i), outs, FRZ);
         tick();
      end
      @(negedge clk); chk("to_err", outs, ERR);
      tick(); req = 1'b0;
      @(negedge clk); chk("to_after", outs, IDLE);
      chk("to_stall", {4'd0, stall}, 8'd15);

      // Saturation: held load-use stalls every cycle.
      do_reset();
      mr = 1'b1; rd = 5'd4; rs1 = 5'd4; u1 = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 14) chk("sat_c14", {4'd0, stall}, 8'd14);
         if (i == 15) chk("sat_c15", {4'd0, stall}, 8'd15);
      end
      chk("sat_c20", {4'd0, stall}, 8'd15);
      clr_in();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
